// File: rtl/note_pixel_classifier_pkg.sv
// Shared constants and types for the note classifier and the colour stage.
package note_pixel_classifier_pkg;

  // Buffer and screen geometry
  localparam int NUM_SLOTS  = 8;
  localparam int H_ACTIVE   = 640;
  localparam int SCROLL_PX  = 2;
  localparam int STAFF_Y0   = 160;
  localparam int LINE_SP    = 16;
  localparam int NUM_LINES  = 5;
  localparam int NOTE_W     = 12;
  localparam int NOTE_H     = 8;
  localparam int PLAYHEAD_X = 80;
  localparam int MAX_PITCH  = 8;

  // Pixel-type bit indices
  localparam int PT_NOTE  = 0;
  localparam int PT_STAFF = 1;
  localparam int PT_TEXT  = 2;
  localparam int PT_RSVD  = 3;
  localparam int PT_PLAY  = 4;

  // Pixel-type one-hot codes
  localparam logic [4:0] PT_NOTE_OH  = 5'b00001;
  localparam logic [4:0] PT_STAFF_OH = 5'b00010;
  localparam logic [4:0] PT_TEXT_OH  = 5'b00100;
  localparam logic [4:0] PT_PLAY_OH  = 5'b10000;

  typedef enum logic [1:0] {
    INSTR_VIOLIN   = 2'd0,
    INSTR_PIANO    = 2'd1,
    INSTR_ELECTRIC = 2'd2,
    INSTR_DEFAULT  = 2'd3
  } instr_e;

  typedef struct packed {
    logic        valid;
    logic [10:0] x;
    logic [3:0]  pitch;
    logic [1:0]  instr;
  } slot_t;

  // Staff positions above the top line clamp to the top line.
  function automatic logic [3:0] sat_pitch(input logic [3:0] p);
    return (p > 4'(MAX_PITCH)) ? 4'(MAX_PITCH) : p;
  endfunction

  // Vertical centre of a note box for a staff position.
  function automatic logic [10:0] note_cy(input logic [3:0] p);
    return 11'(STAFF_Y0 + 4 * LINE_SP) - 11'(p) * 11'(LINE_SP / 2);
  endfunction

  // True when the row lies on one of the staff lines.
  function automatic logic is_staff(input logic [9:0] y);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_LINES; k++)
      if ({1'b0, y} == 11'(STAFF_Y0 + k * LINE_SP)) hit = 1'b1;
    return hit;
  endfunction

endpackage

// File: rtl/note_pixel_classifier_slot.sv
// One note slot: state registers, per-frame scroll/free and pixel hit tests.
module note_slot
  import note_pixel_classifier_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_start,
  input  logic       load,
  input  logic [3:0] load_pitch,
  input  logic [1:0] load_instr,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  output logic       valid,
  output logic       will_free,
  output logic       valid_next,
  output logic [1:0] instr,
  output logic       hit,
  output logic       playing
);

  slot_t       cur;
  slot_t       nxt;
  logic [10:0] px;
  logic [10:0] py;
  logic [10:0] cy;
  logic        in_x;
  logic        in_y;

  // Next slot state: scroll or free on frame_start, then an allocation overrides.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    nxt       = cur;
    will_free = 1'b0;
    if (frame_start && cur.valid) begin
      if (cur.x < 11'(SCROLL_PX)) begin
        nxt.valid = 1'b0;
        will_free = 1'b1;
      end else begin
        nxt.x = cur.x - 11'(SCROLL_PX);
      end
    end
    if (load) begin
      nxt.valid = 1'b1;
      nxt.x     = 11'(H_ACTIVE);
      nxt.pitch = sat_pitch(load_pitch);
      nxt.instr = load_instr;
    end
  end

  // Slot state register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the slot store is small and must come up empty, so every field is reset.
    if (!reset_n) cur <= '0;
    // NOTE: sequential state uses non-blocking assignment only.
    else          cur <= nxt;
  end

  // Hit tests against the current (pre-update) position, widened to 11 bits.
  always_comb begin
    px      = {1'b0, pix_x};
    py      = {1'b0, pix_y};
    cy      = note_cy(cur.pitch);
    in_x    = (px >= cur.x) && (px < cur.x + 11'(NOTE_W));
    in_y    = (py >= cy - 11'(NOTE_H / 2)) && (py < cy + 11'(NOTE_H / 2));
    hit     = cur.valid && in_x && in_y;
    playing = hit && (cur.x <= 11'(PLAYHEAD_X)) && (11'(PLAYHEAD_X) < cur.x + 11'(NOTE_W));
  end

  assign valid      = cur.valid;
  assign valid_next = nxt.valid;
  assign instr      = cur.instr;

endmodule

// File: rtl/note_pixel_classifier.sv
// Scrolling note buffer and two-stage pixel classifier feeding the colour stage.
module note_pixel_classifier
  import note_pixel_classifier_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_start,
  input  logic       note_valid,
  output logic       note_ready,
  input  logic [3:0] note_pitch,
  input  logic [1:0] note_instr,
  input  logic       pix_valid,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       text_in,
  output logic       out_valid,
  output logic [4:0] pixel_type,
  output logic [1:0] instrument_type,
  output logic [3:0] note_count
);

  logic [NUM_SLOTS-1:0]      valid_v, free_v, next_v, load_v, hit_v, play_v;
  logic [NUM_SLOTS-1:0][1:0] instr_v;
  logic                      found;
  logic [3:0]                count_next;

  logic                      s1_valid, s1_staff, s1_text;
  logic [NUM_SLOTS-1:0]      s1_hit, s1_play, sel_v;
  logic [NUM_SLOTS-1:0][1:0] s1_instr;
  logic [4:0]                type_next;
  logic [1:0]                instr_next;
  logic                      sel_found;

  assign note_ready = ~&valid_v;

  // Allocator: lowest slot that is free now or is being freed by this frame_start.
  always_comb begin
    load_v = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!found && (!valid_v[i] || free_v[i])) begin
        load_v[i] = 1'b1;
        found     = 1'b1;
      end
    end
    if (!(note_valid && note_ready)) load_v = '0;
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    note_slot u_slot (
      .clk        (clk),
      .reset_n    (reset_n),
      .frame_start(frame_start),
      .load       (load_v[g]),
      .load_pitch (note_pitch),
      .load_instr (note_instr),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .valid      (valid_v[g]),
      .will_free  (free_v[g]),
      .valid_next (next_v[g]),
      .instr      (instr_v[g]),
      .hit        (hit_v[g]),
      .playing    (play_v[g])
    );
  end

  // Occupancy of the slot state that the next edge will load.
  always_comb begin
    count_next = '0;
    for (int i = 0; i < NUM_SLOTS; i++) count_next = count_next + {3'b000, next_v[i]};
  end

  // Occupied-slot counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) note_count <= '0;
    else          note_count <= count_next;
  end

  // S1: capture per-slot hits, staff/text flags and the instruments they refer to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_hit   <= '0;
      s1_play  <= '0;
      s1_staff <= 1'b0;
      s1_text  <= 1'b0;
      s1_instr <= '0;
    end else begin
      s1_valid <= pix_valid;
      s1_hit   <= hit_v;
      s1_play  <= play_v;
      s1_staff <= is_staff(pix_y);
      s1_text  <= text_in;
      s1_instr <= instr_v;
    end
  end

  // S2 reduce: priority select and lowest-index instrument of the winning class.
  always_comb begin
    type_next  = '0;
    instr_next = '0;
    sel_found  = 1'b0;
    sel_v      = (|s1_play) ? s1_play : s1_hit;
    if (s1_valid) begin
      if (|s1_play)     type_next = PT_PLAY_OH;
      else if (|s1_hit) type_next = PT_NOTE_OH;
      else if (s1_text) type_next = PT_TEXT_OH;
      else if (s1_staff) type_next = PT_STAFF_OH;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (!sel_found && sel_v[i]) begin
          instr_next = s1_instr[i];
          sel_found  = 1'b1;
        end
      end
    end
  end

  // S2 output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid       <= 1'b0;
      pixel_type      <= '0;
      instrument_type <= '0;
    end else begin
      out_valid       <= s1_valid;
      pixel_type      <= type_next;
      instrument_type <= instr_next;
    end
  end

endmodule

// File: tb/tb_note_pixel_classifier.sv
// Directed bench with a behavioural note-buffer model checked every cycle.
module tb_note_pixel_classifier;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       note_valid = 1'b0;
  logic       note_ready;
  logic [3:0] note_pitch = '0;
  logic [1:0] note_instr = '0;
  logic       pix_valid = 1'b0;
  logic [9:0] pix_x = '0;
  logic [9:0] pix_y = '0;
  logic       text_in = 1'b0;
  logic       out_valid;
  logic [4:0] pixel_type;
  logic [1:0] instrument_type;
  logic [3:0] note_count;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  note_pixel_classifier dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .frame_start    (frame_start),
    .note_valid     (note_valid),
    .note_ready     (note_ready),
    .note_pitch     (note_pitch),
    .note_instr     (note_instr),
    .pix_valid      (pix_valid),
    .pix_x          (pix_x),
    .pix_y          (pix_y),
    .text_in        (text_in),
    .out_valid      (out_valid),
    .pixel_type     (pixel_type),
    .instrument_type(instrument_type),
    .note_count     (note_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit mv[8];
  int mx[8];
  int mp[8];
  int mi[8];
  bit e1_v, e2_v;
  int e1_t, e2_t, e1_i, e2_i;

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(mv[i]);
    return c;
  endfunction

  function automatic void classify(input bit v, input int px, input int py, input bit txt,
                                   output int t, output int ins);
    int ip, ih, cy;
    bit staff;
    ip = -1; ih = -1; staff = 1'b0; t = 0; ins = 0;
    if (v) begin
      for (int k = 0; k < 5; k++) if (py == 160 + 16 * k) staff = 1'b1;
      for (int i = 7; i >= 0; i--) begin
        cy = 224 - mp[i] * 8;
        if (mv[i] && mx[i] <= px && px < mx[i] + 12 && py >= cy - 4 && py < cy + 4) begin
          ih = i;
          if (mx[i] <= 80 && 80 < mx[i] + 12) ip = i;
        end
      end
      if (ip >= 0)      begin t = 16; ins = mi[ip]; end
      else if (ih >= 0) begin t = 1;  ins = mi[ih]; end
      else if (txt)     t = 4;
      else if (staff)   t = 2;
    end
  endfunction

  always @(posedge clk or negedge reset_n) begin
    bit rdy;
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin mv[i] = 0; mx[i] = 0; mp[i] = 0; mi[i] = 0; end
      e1_v = 0; e2_v = 0; e1_t = 0; e2_t = 0; e1_i = 0; e2_i = 0;
    end else begin
      e2_v = e1_v; e2_t = e1_t; e2_i = e1_i;
      e1_v = pix_valid;
      classify(pix_valid, int'(pix_x), int'(pix_y), text_in, e1_t, e1_i);
      rdy = (m_count() < 8);
      if (frame_start)
        for (int i = 0; i < 8; i++)
          if (mv[i]) begin
            if (mx[i] < 2) mv[i] = 0;
            else           mx[i] -= 2;
          end
      if (note_valid && rdy) begin
        for (int i = 0; i < 8; i++)
          if (!mv[i]) begin
            mv[i] = 1; mx[i] = 640;
            mp[i] = (note_pitch > 8) ? 8 : int'(note_pitch);
            mi[i] = int'(note_instr);
            break;
          end
      end
    end
  end

  // Compare DUT against model on every cycle out of reset.
  always @(negedge clk) begin
    if (cmp_en && reset_n) begin
      check("model_out_valid", int'(out_valid), int'(e2_v));
      check("model_pixel_type", int'(pixel_type), e2_t);
      check("model_instr", int'(instrument_type), e2_i);
      check("model_note_count", int'(note_count), m_count());
      check("model_note_ready", int'(note_ready), int'(m_count() < 8));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic reset_pulse();
    @(negedge clk);
    reset_n = 1'b0; frame_start = 0; note_valid = 0; pix_valid = 0; text_in = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic write(input int p, input int ins);
    @(negedge clk);
    note_valid = 1; note_pitch = 4'(p); note_instr = 2'(ins);
    @(negedge clk);
    note_valid = 0;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      @(negedge clk); frame_start = 1;
      @(negedge clk); frame_start = 0;
    end
  endtask

  task automatic frame_write(input int p, input int ins);
    @(negedge clk);
    frame_start = 1; note_valid = 1; note_pitch = 4'(p); note_instr = 2'(ins);
    @(negedge clk);
    frame_start = 0; note_valid = 0;
  endtask

  task automatic probe(input string name, input int x, input int y, input bit t,
                       input int exp_t, input int exp_i);
    @(negedge clk);
    pix_valid = 1; pix_x = 10'(x); pix_y = 10'(y); text_in = t;
    @(negedge clk);
    pix_valid = 0; text_in = 0;
    @(negedge clk);
    check({name, "_valid"}, int'(out_valid), 1);
    check({name, "_type"}, int'(pixel_type), exp_t);
    check({name, "_instr"}, int'(instrument_type), exp_i);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_pixel_type", int'(pixel_type), 0);
    check("reset_note_count", int'(note_count), 0);
    check("reset_note_ready", int'(note_ready), 1);
    reset_n = 1'b1;
    cmp_en  = 1'b1;

    // Staff only
    probe("staff_only", 85, 160, 0, 5'b00010, 0);

    // Playing note at the playhead, x = 640 - 560 = 80
    write(0, 1);
    frames(280);
    probe("play_hit", 85, 224, 0, 5'b10000, 1);
    probe("above_box", 85, 219, 0, 5'b00000, 0);
    probe("box_top", 85, 220, 0, 5'b10000, 1);

    // Non-playing note at x = 140, and text priority
    reset_pulse();
    write(0, 1);
    frames(250);
    probe("note_hit", 145, 224, 0, 5'b00001, 1);
    probe("note_over_text", 145, 224, 1, 5'b00001, 1);
    reset_pulse();
    probe("text_only", 145, 224, 1, 5'b00100, 0);

    // Full buffer, dropped writes
    reset_pulse();
    for (int i = 0; i < 8; i++) write(i, i % 4);
    check("full_ready", int'(note_ready), 0);
    check("full_count", int'(note_count), 8);
    write(3, 3);
    check("drop_count", int'(note_count), 8);
    frame_write(2, 2);
    check("full_frame_write_count", int'(note_count), 8);
    probe("full_scrolled", 639, 224, 0, 5'b00001, 0);

    // Single note reaches x = 0 then is freed
    reset_pulse();
    write(0, 1);
    frames(320);
    probe("edge_hit", 0, 224, 0, 5'b00001, 1);
    frames(1);
    check("freed_count", int'(note_count), 0);
    check("freed_ready", int'(note_ready), 1);

    // New note reuses a slot freed in the same cycle, lands unscrolled
    reset_pulse();
    write(0, 1);
    frames(320);
    write(0, 3);
    frame_write(15, 2);
    check("reuse_count", int'(note_count), 2);
    probe("reuse_new_note", 645, 160, 0, 5'b00001, 2);
    probe("reuse_old_note", 639, 224, 0, 5'b00001, 3);

    // Asynchronous reset mid-stream
    reset_pulse();
    write(0, 2);
    write(0, 1);
    write(4, 0);
    frames(280);
    @(negedge clk);
    pix_valid = 1; pix_x = 10'd85; pix_y = 10'd224;
    repeat (3) @(negedge clk);
    check("pre_reset_type", int'(pixel_type), 5'b10000);
    check("pre_reset_instr", int'(instrument_type), 2);
    check("pre_reset_count", int'(note_count), 3);
    #2 reset_n = 1'b0;
    #1;
    check("async_out_valid", int'(out_valid), 0);
    check("async_pixel_type", int'(pixel_type), 0);
    check("async_count", int'(note_count), 0);
    check("async_ready", int'(note_ready), 1);
    @(negedge clk);
    pix_valid = 0;
    reset_n = 1'b1;
    probe("post_reset", 85, 224, 0, 5'b00010, 0);
    check("post_reset_count", int'(note_count), 0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
